// File: rtl/nor_gate_bank.sv
// Bank of independent clocked 2-input NOR channels with input synchronisers,
// an output stability filter, registered pad enables and saturating change counters.
module nor_gate_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       oe,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       y,
  output logic [CHANNELS-1:0]       y_en,
  output logic [CHANNELS-1:0]       y_change,
  output logic [CHANNELS*CNT_W-1:0] edge_cnt
);

  // fcnt only ever needs to hold FILTER_LEN-1; keep at least one bit for FILTER_LEN=1.
  localparam int                FCNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [CHANNELS-1:0] y_en_q;
  logic [CHANNELS-1:0] y_en_d;

  assign y_en_d = oe & {CHANNELS{en}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_en_q <= '0;
    end else begin
      y_en_q <= y_en_d;
    end
  end

  assign y_en = y_en_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] a_sync_q;
      logic [SYNC_STAGES-1:0] b_sync_q;
      logic                   raw;
      logic [FCNT_W-1:0]      fcnt_q;
      logic [FCNT_W-1:0]      fcnt_d;
      logic                   y_q;
      logic                   y_d;
      logic                   chg_q;
      logic                   chg_d;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_sync_q <= '0;
          b_sync_q <= '0;
        end else begin
          a_sync_q[0] <= a[gi];
          b_sync_q[0] <= b[gi];
          for (int s = 1; s < SYNC_STAGES; s++) begin
            a_sync_q[s] <= a_sync_q[s-1];
            b_sync_q[s] <= b_sync_q[s-1];
          end
        end
      end

      assign raw = ~(a_sync_q[SYNC_STAGES-1] | b_sync_q[SYNC_STAGES-1]);

      // Any cycle without a pending deviation (or with en low) restarts the filter.
      always_comb begin
        fcnt_d = '0;
        y_d    = y_q;
        chg_d  = 1'b0;
        if (en && (raw != y_q)) begin
          if (fcnt_q == FCNT_MAX) begin
            y_d   = raw;
            chg_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end

      always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
          cnt_d = '0;
        end else if (chg_q && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fcnt_q <= '0;
          y_q    <= 1'b1;
          chg_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          fcnt_q <= fcnt_d;
          y_q    <= y_d;
          chg_q  <= chg_d;
          cnt_q  <= cnt_d;
        end
      end

      assign y[gi]                      = y_q;
      assign y_change[gi]               = chg_q;
      assign edge_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_nor_gate_bank.sv
// Directed bench for nor_gate_bank (CNT_W=2 so counter saturation is reachable).
module tb_nor_gate_bank;

  localparam int CH = 4;
  localparam int CW = 2;

  logic            clk;
  logic            rst;
  logic            en;
  logic [CH-1:0]   a;
  logic [CH-1:0]   b;
  logic [CH-1:0]   oe;
  logic            cnt_clr;
  logic [CH-1:0]   y;
  logic [CH-1:0]   y_en;
  logic [CH-1:0]   y_change;
  logic [CH*CW-1:0] edge_cnt;

  int errors = 0;
  int checks = 0;

  nor_gate_bank #(
    .CHANNELS(CH),
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .a(a),
    .b(b),
    .oe(oe),
    .cnt_clr(cnt_clr),
    .y(y),
    .y_en(y_en),
    .y_change(y_change),
    .edge_cnt(edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen_chg;
    logic seen_low;
    logic [1:0] exp_cnt;
    logic exp_a1;

    rst = 1'b1; en = 1'b0; a = '0; b = '0; oe = '0; cnt_clr = 1'b0;
    tick(2);
    check("rst_y", y, 4'hF);
    check("rst_y_en", y_en, 4'h0);
    check("rst_y_change", y_change, 4'h0);
    check("rst_edge_cnt", edge_cnt, 8'h00);

    // Idle after release: NOR(0,0)=1 everywhere, pad enables follow one edge later.
    rst = 1'b0; oe = 4'hF; en = 1'b1;
    tick(1);
    check("idle_y_en", y_en, 4'hF);
    check("idle_y", y, 4'hF);
    tick(9);
    check("idle_y_10", y, 4'hF);
    check("idle_chg_10", y_change, 4'h0);
    check("idle_cnt_10", edge_cnt, 8'h00);

    // Channel 0: a[0] rises; y[0] falls on the 6th edge.
    a[0] = 1'b1;
    tick(5);
    check("a0_y_edge5", y, 4'hF);
    tick(1);
    check("a0_y_edge6", y, 4'hE);
    check("a0_chg_edge6", y_change, 4'h1);
    tick(1);
    check("a0_chg_edge7", y_change, 4'h0);
    check("a0_cnt_edge7", edge_cnt, 8'h01);
    a[0] = 1'b0;
    tick(6);
    check("a0_back_y", y, 4'hF);
    check("a0_back_chg", y_change, 4'h1);
    tick(1);
    check("a0_back_cnt", edge_cnt, 8'h02);

    // Channel 2: 3-cycle pulse must be rejected.
    b[2] = 1'b1;
    tick(3);
    b[2] = 1'b0;
    seen_chg = 1'b0; seen_low = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_chg |= y_change[2];
      seen_low |= ~y[2];
    end
    check("b2_short_chg", {31'd0, seen_chg}, 32'd0);
    check("b2_short_low", {31'd0, seen_low}, 32'd0);
    check("b2_short_cnt", edge_cnt, 8'h02);

    // Channel 2: 4-cycle pulse passes and then returns.
    b[2] = 1'b1;
    tick(4);
    b[2] = 1'b0;
    tick(2);
    check("b2_long_fall_y", y, 4'hB);
    check("b2_long_fall_chg", y_change, 4'h4);
    tick(1);
    check("b2_long_mid_cnt", edge_cnt, 8'h12);
    tick(3);
    check("b2_long_rise_y", y, 4'hF);
    check("b2_long_rise_chg", y_change, 4'h4);
    tick(1);
    check("b2_long_cnt", edge_cnt, 8'h22);

    // Channel 1: five slow toggles saturate the 2-bit counter at 3.
    exp_a1 = 1'b0;
    exp_cnt = 2'd0;
    for (int k = 1; k <= 5; k++) begin
      exp_a1 = ~exp_a1;
      a[1] = exp_a1;
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      tick(8);
      check($sformatf("a1_tog%0d_y1", k), {31'd0, y[1]}, {31'd0, ~exp_a1});
      check($sformatf("a1_tog%0d_cnt", k), {30'd0, edge_cnt[3:2]}, {30'd0, exp_cnt});
    end

    // Clear coincident with a y_change[1]: clear wins, event dropped.
    a[1] = 1'b0;
    tick(6);
    check("clr_chg", y_change, 4'h2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("clr_cnt", edge_cnt, 8'h00);
    tick(1);
    check("clr_cnt_hold", edge_cnt, 8'h00);

    // en=0 freezes the filter and drops pad enables.
    en = 1'b0;
    a[3] = 1'b1;
    tick(20);
    check("en0_y", y, 4'hF);
    check("en0_y_en", y_en, 4'h0);
    en = 1'b1;
    tick(3);
    check("en1_y_edge3", y, 4'hF);
    check("en1_y_en", y_en, 4'hF);
    tick(1);
    check("en1_y_edge4", y, 4'h7);
    check("en1_chg_edge4", y_change, 4'h8);
    a[3] = 1'b0;
    tick(7);
    check("a3_back_y", y, 4'hF);
    check("a3_cnt", edge_cnt, 8'h80);

    // Asynchronous reset in the middle of a filter run (fcnt=2 on channel 0).
    a[0] = 1'b1;
    tick(4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_y", y, 4'hF);
    check("arst_y_en", y_en, 4'h0);
    check("arst_cnt", edge_cnt, 8'h00);
    check("arst_chg", y_change, 4'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("post_rst_y_edge5", y, 4'hF);
    tick(1);
    check("post_rst_y_edge6", y, 4'hE);
    check("post_rst_chg_edge6", y_change, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
